// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_pkg
//  Purpose  : Shared types and helpers for the CSR-driven pixel stream path.
//  Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

  // Loader control states: filling/idle, streaming one frame, frame finished
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } loader_state_t;

  // Number of pixels making up one frame
  function automatic int frame_pixels(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  // Width needed to hold a FIFO occupancy of 0..depth inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : input_fifo
//  Purpose  : Synchronous FIFO with registered storage and occupancy output.
//             Read data is presented combinationally from the head entry.
//  Revision : 1.0 - initial release
// ============================================================================
module input_fifo
  import pixel_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers carry one wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/csr_pixel_loader.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pixel_loader
//  Purpose  : CPU pushes pixels through CSR writes into a FIFO; on start the
//             block emits one IMG_W x IMG_H frame as a valid/ready stream
//             with sof/eol/eof markers.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_pixel_loader
  import pixel_stream_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 960,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PIX_W-1:0]             csr_pixel_w,
  input  logic                         csr_pixel_we,
  input  logic                         csr_start,
  input  logic                         csr_clear,
  output logic                         csr_full_r,
  output logic [$clog2(FIFO_DEPTH):0]  csr_level_r,
  output logic                         csr_overflow_r,
  output logic [CNT_W-1:0]             pixel_count,
  output logic [PIX_W-1:0]             px_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         sof_out,
  output logic                         eol_out,
  output logic                         eof_out,
  output logic                         busy,
  output logic                         done
);

  localparam int FRAME_PIXELS = frame_pixels(IMG_W, IMG_H);
  localparam int COL_W        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W        = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  loader_state_t    state;
  loader_state_t    state_next;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             accept;
  logic             handshake;
  logic             last_col;
  logic             last_row;
  logic             load;

  // A pop in the same cycle never frees room for a write: full is used as-is
  assign accept = csr_pixel_we && !csr_full_r && !csr_clear &&
                  (pixel_count < CNT_W'(FRAME_PIXELS)) && (state != DONE);

  assign handshake = valid_out && ready_in;
  assign last_col  = (col == COL_W'(IMG_W - 1));
  assign last_row  = (row == ROW_W'(IMG_H - 1));

  // Do not refill the output register behind the final pixel of the frame
  assign load = (state == STREAM) && !fifo_empty && (!valid_out || ready_in) &&
                !(handshake && last_col && last_row);

  input_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (csr_clear),
    .wr_en (accept),
    .din   (csr_pixel_w),
    .rd_en (load),
    .dout  (fifo_dout),
    .full  (csr_full_r),
    .empty (fifo_empty),
    .level (csr_level_r)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (csr_start) state_next = STREAM;
      STREAM:  if (handshake && last_col && last_row) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (csr_clear) state_next = IDLE;
  end

  // Write counter and sticky overflow flag for dropped writes
  always_ff @(posedge clk) begin
    if (rst || csr_clear) begin
      pixel_count    <= '0;
      csr_overflow_r <= 1'b0;
    end else begin
      if (accept)                 pixel_count    <= pixel_count + 1'b1;
      if (csr_pixel_we && !accept) csr_overflow_r <= 1'b1;
    end
  end

  // Output register plus column/row position of the pixel it holds
  always_ff @(posedge clk) begin
    if (rst || csr_clear) begin
      valid_out <= 1'b0;
      px_out    <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (handshake) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (load) begin
        px_out    <= fifo_dout;
        valid_out <= 1'b1;
      end else if (handshake) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign sof_out = valid_out && (col == '0) && (row == '0);
  assign eol_out = valid_out && last_col;
  assign eof_out = valid_out && last_col && last_row;
  assign busy    = (state == STREAM);
  assign done    = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_csr_pixel_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_pixel_loader
//  Purpose  : Self-checking bench for csr_pixel_loader (4x2 frame, 8-deep FIFO)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_pixel_loader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DEPTH = 8;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef struct packed {
    logic [7:0] px;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  csr_pixel_w = '0;
  logic        csr_pixel_we = 1'b0;
  logic        csr_start = 1'b0;
  logic        csr_clear = 1'b0;
  logic        csr_full_r;
  logic [3:0]  csr_level_r;
  logic        csr_overflow_r;
  logic [31:0] pixel_count;
  logic [7:0]  px_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        sof_out, eol_out, eof_out, busy, done;

  int    checks = 0;
  int    errors = 0;
  int    hs_count = 0;
  int    cyc = 0;
  int    first_hs_cyc = -1;
  int    last_hs_cyc = -1;
  int    push_idx = 0;
  beat_t exp_q[$];
  bit    prev_stall = 0;
  bit    prev_eof = 0;
  beat_t prev_beat;

  csr_pixel_loader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(8), .FIFO_DEPTH(DEPTH), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .csr_pixel_w(csr_pixel_w), .csr_pixel_we(csr_pixel_we),
    .csr_start(csr_start), .csr_clear(csr_clear), .csr_full_r(csr_full_r),
    .csr_level_r(csr_level_r), .csr_overflow_r(csr_overflow_r),
    .pixel_count(pixel_count), .px_out(px_out), .valid_out(valid_out),
    .ready_in(ready_in), .sof_out(sof_out), .eol_out(eol_out), .eof_out(eof_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: compare every handshake, check stalls and frame end
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_eof) begin
        checks++;
        if (done !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL frame_end: done=%b valid=%b busy=%b, required 1 0 0", done, valid_out, busy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (valid_out !== 1'b1 || px_out !== prev_beat.px || sof_out !== prev_beat.sof ||
            eol_out !== prev_beat.eol || eof_out !== prev_beat.eof) begin
          errors++;
          $display("FAIL stall_hold: valid=%b px=%h flags=%b%b%b, required 1 %h %b%b%b",
                   valid_out, px_out, sof_out, eol_out, eof_out,
                   prev_beat.px, prev_beat.sof, prev_beat.eol, prev_beat.eof);
        end
      end
      prev_eof = 0;
      if (valid_out && ready_in) begin
        hs_count++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        prev_eof = eof_out;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: px=%h with empty scoreboard", px_out);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (px_out !== e.px || sof_out !== e.sof || eol_out !== e.eol || eof_out !== e.eof) begin
            errors++;
            $display("FAIL beat: px=%h sof/eol/eof=%b%b%b, required %h %b%b%b",
                     px_out, sof_out, eol_out, eof_out, e.px, e.sof, e.eol, e.eof);
          end
        end
      end
      prev_stall = valid_out && !ready_in && !csr_clear;
      prev_beat  = '{px: px_out, sof: sof_out, eol: eol_out, eof: eof_out};
    end else begin
      prev_stall = 0;
      prev_eof   = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d);
    beat_t b;
    b.px  = d;
    b.sof = (push_idx == 0);
    b.eol = ((push_idx % IMG_W) == IMG_W - 1);
    b.eof = (push_idx == NPIX - 1);
    exp_q.push_back(b);
    push_idx++;
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_ok);
    csr_pixel_w  = d;
    csr_pixel_we = 1'b1;
    tick();
    csr_pixel_we = 1'b0;
    if (expect_ok) push_exp(d);
  endtask

  task automatic do_clear();
    csr_clear = 1'b1;
    tick();
    csr_clear = 1'b0;
    exp_q.delete();
    push_idx = 0;
  endtask

  task automatic start_pulse();
    csr_start = 1'b1;
    tick();
    csr_start = 1'b0;
  endtask

  // Step until done, driving ready either high or with the 1,0,0,1 pattern
  task automatic wait_done(input bit toggle, input int max_cycles);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      ready_in = toggle ? pat[n % 4] : 1'b1;
      tick();
      n++;
    end
    ready_in = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({valid_out, sof_out, eol_out, eof_out, busy, done, csr_full_r, csr_overflow_r} !== 8'b0 ||
        csr_level_r !== 4'd0 || pixel_count !== 32'd0 || px_out !== 8'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b done=%b full=%b ovf=%b level=%0d count=%0d px=%h, required all 0",
               valid_out, busy, done, csr_full_r, csr_overflow_r, csr_level_r, pixel_count, px_out);
    end
  endtask

  task automatic test_basic_frame();
    int hs0;
    ready_in = 1'b1;
    for (int i = 0; i < NPIX; i++) wr(8'h10 + 8'(i), 1'b1);
    checks++;
    if (csr_level_r !== 4'd8 || csr_full_r !== 1'b1 || pixel_count !== 32'd8 ||
        csr_overflow_r !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_fill: level=%0d full=%b count=%0d ovf=%b valid=%b, required 8 1 8 0 0",
               csr_level_r, csr_full_r, pixel_count, csr_overflow_r, valid_out);
    end
    hs0 = hs_count;
    first_hs_cyc = -1;
    start_pulse();
    wait_done(1'b0, 40);
    tick();
    checks++;
    if (hs_count - hs0 != NPIX || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: handshakes=%0d left=%0d busy=%b, required 8 0 0",
               hs_count - hs0, exp_q.size(), busy);
    end
    checks++;
    if (last_hs_cyc - first_hs_cyc != NPIX - 1) begin
      errors++;
      $display("FAIL basic_throughput: span=%0d cycles, required %0d", last_hs_cyc - first_hs_cyc, NPIX - 1);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    do_clear();
    for (int i = 0; i < NPIX; i++) wr(8'h60 + 8'(i), 1'b1);
    hs0 = hs_count;
    start_pulse();
    wait_done(1'b1, 80);
    tick();
    checks++;
    if (hs_count - hs0 != NPIX || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_count: handshakes=%0d left=%0d, required 8 0", hs_count - hs0, exp_q.size());
    end
  endtask

  task automatic test_overflow_full();
    do_clear();
    for (int i = 0; i < DEPTH - 1; i++) wr(8'h80 + 8'(i), 1'b1);
    checks++;
    if (csr_full_r !== 1'b0 || csr_level_r !== 4'd7) begin
      errors++;
      $display("FAIL full_before: full=%b level=%0d, required 0 7", csr_full_r, csr_level_r);
    end
    wr(8'h87, 1'b1);
    checks++;
    if (csr_full_r !== 1'b1 || csr_overflow_r !== 1'b0) begin
      errors++;
      $display("FAIL full_at_8: full=%b ovf=%b, required 1 0", csr_full_r, csr_overflow_r);
    end
    wr(8'h88, 1'b0);
    checks++;
    if (csr_overflow_r !== 1'b1 || csr_level_r !== 4'd8 || pixel_count !== 32'd8) begin
      errors++;
      $display("FAIL overflow: ovf=%b level=%0d count=%0d, required 1 8 8", csr_overflow_r, csr_level_r, pixel_count);
    end
    do_clear();
    checks++;
    if (csr_overflow_r !== 1'b0 || csr_level_r !== 4'd0 || pixel_count !== 32'd0 || csr_full_r !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b level=%0d count=%0d full=%b, required 0 0 0 0",
               csr_overflow_r, csr_level_r, pixel_count, csr_full_r);
    end
  endtask

  task automatic test_latency();
    do_clear();
    ready_in = 1'b0;
    wr(8'h55, 1'b1);
    wr(8'h56, 1'b1);
    start_pulse();
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_lat_s1: valid=%b busy=%b, required 0 1", valid_out, busy);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || px_out !== 8'h55 || sof_out !== 1'b1 || csr_level_r !== 4'd1) begin
      errors++;
      $display("FAIL start_lat_s2: valid=%b px=%h sof=%b level=%0d, required 1 55 1 1",
               valid_out, px_out, sof_out, csr_level_r);
    end
    do_clear();
    start_pulse();
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL empty_stream: valid=%b, required 0", valid_out);
    end
    wr(8'hAB, 1'b1);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL write_lat_t1: valid=%b, required 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || px_out !== 8'hAB || sof_out !== 1'b1 || eol_out !== 1'b0) begin
      errors++;
      $display("FAIL write_lat_t2: valid=%b px=%h sof=%b eol=%b, required 1 ab 1 0",
               valid_out, px_out, sof_out, eol_out);
    end
    do_clear();
    ready_in = 1'b1;
  endtask

  task automatic test_clear_mid_and_done_write();
    int hs0;
    int n;
    do_clear();
    ready_in = 1'b1;
    for (int i = 0; i < NPIX; i++) wr(8'h30 + 8'(i), 1'b1);
    hs0 = hs_count;
    start_pulse();
    n = 0;
    while (hs_count - hs0 < 3 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (hs_count - hs0 != 3) begin
      errors++;
      $display("FAIL clear_mid_hs: handshakes=%0d, required 3", hs_count - hs0);
    end
    ready_in = 1'b0;
    do_clear();
    checks++;
    if (valid_out !== 1'b0 || csr_level_r !== 4'd0 || pixel_count !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: valid=%b level=%0d count=%0d busy=%b done=%b, required 0 0 0 0 0",
               valid_out, csr_level_r, pixel_count, busy, done);
    end
    ready_in = 1'b1;
    for (int i = 0; i < NPIX; i++) wr(8'h20 + 8'(i), 1'b1);
    start_pulse();
    wait_done(1'b0, 40);
    wr(8'h99, 1'b0);
    checks++;
    if (csr_overflow_r !== 1'b1 || csr_level_r !== 4'd0 || pixel_count !== 32'd8 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_write: ovf=%b level=%0d count=%0d done=%b, required 1 0 8 1",
               csr_overflow_r, csr_level_r, pixel_count, done);
    end
  endtask

  task automatic test_frame_cap();
    do_clear();
    ready_in = 1'b0;
    for (int i = 0; i < NPIX; i++) wr(8'h40 + 8'(i), 1'b1);
    start_pulse();
    tick();
    checks++;
    if (csr_level_r !== 4'd7 || csr_full_r !== 1'b0 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL cap_setup: level=%0d full=%b valid=%b, required 7 0 1", csr_level_r, csr_full_r, valid_out);
    end
    wr(8'h77, 1'b0);
    checks++;
    if (csr_overflow_r !== 1'b1 || pixel_count !== 32'd8 || csr_level_r !== 4'd7) begin
      errors++;
      $display("FAIL frame_cap: ovf=%b count=%0d level=%0d, required 1 8 7", csr_overflow_r, pixel_count, csr_level_r);
    end
    wait_done(1'b0, 40);
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cap_drain: %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    do_clear();
    csr_pixel_w  = 8'hEE;
    csr_pixel_we = 1'b1;
    csr_start    = 1'b1;
    csr_clear    = 1'b1;
    tick();
    csr_pixel_we = 1'b0;
    csr_start    = 1'b0;
    csr_clear    = 1'b0;
    checks++;
    if (csr_overflow_r !== 1'b0 || csr_level_r !== 4'd0 || pixel_count !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: ovf=%b level=%0d count=%0d busy=%b, required 0 0 0 0",
               csr_overflow_r, csr_level_r, pixel_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overflow_full();
    test_latency();
    test_clear_mid_and_done_write();
    test_frame_cap();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
